// File: rtl/vip_axis_pkt_if.sv
`default_nettype none
// ============================================================================
// Module      : vip_axis_pkt_if
// Description : AXI-Stream bundle (valid/ready/data/keep/last) with master and
//               slave views, used for both directions of the VIP bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface vip_axis_pkt_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/vip_axis_pkt.sv
`default_nettype none
// ============================================================================
// Module      : vip_axis_pkt
// Description : AXI-Stream virtual-IP bridge: fixed-length request packet ->
//               wide DUT bus + strobe, DUT result bus -> fixed-length response.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_axis_pkt #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int VIP2DUT_WORDS_NUM = 10,
    parameter int DUT2VIP_WORDS_NUM = 10,
    parameter int CNT_WIDTH         = 16
) (
    input  wire                                        s_axis_aclk,
    input  wire                                        s_axis_areset,
    vip_axis_pkt_if.slave                              s_axis,
    vip_axis_pkt_if.master                             m_axis,
    output logic                                       vip2dut_clk,
    output logic [C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0]  vip2dut_bus,
    input  wire                                        dut2vip_valid,
    input  wire  [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0]  dut2vip_bus,
    output logic [CNT_WIDTH-1:0]                       pkt_cnt,
    output logic [CNT_WIDTH-1:0]                       err_short_cnt,
    output logic [CNT_WIDTH-1:0]                       err_long_cnt
);
    localparam int c_RX_W = (VIP2DUT_WORDS_NUM > 1) ? $clog2(VIP2DUT_WORDS_NUM) : 1;
    localparam int c_TX_W = (DUT2VIP_WORDS_NUM > 1) ? $clog2(DUT2VIP_WORDS_NUM) : 1;

    localparam logic [c_RX_W-1:0]    c_RX_LAST = c_RX_W'(VIP2DUT_WORDS_NUM - 1);
    localparam logic [c_RX_W-1:0]    c_RX_ONE  = c_RX_W'(1);
    localparam logic [c_TX_W-1:0]    c_TX_LAST = c_TX_W'(DUT2VIP_WORDS_NUM - 1);
    localparam logic [c_TX_W-1:0]    c_TX_ONE  = c_TX_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    localparam logic [2:0] c_ST_RX     = 3'd0;
    localparam logic [2:0] c_ST_DROP   = 3'd1;
    localparam logic [2:0] c_ST_STROBE = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_TX     = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [c_RX_W-1:0]       r_rx_idx;
    logic [c_TX_W-1:0]       r_tx_idx;
    logic                    r_tready;
    logic [C_DATA_WIDTH-1:0] r_req  [VIP2DUT_WORDS_NUM];
    logic [C_DATA_WIDTH-1:0] r_resp [DUT2VIP_WORDS_NUM];
    logic [CNT_WIDTH-1:0]    r_pkt_cnt;
    logic [CNT_WIDTH-1:0]    r_err_short_cnt;
    logic [CNT_WIDTH-1:0]    r_err_long_cnt;

    logic w_s_hs;
    logic w_m_hs;
    logic w_tx_valid;
    logic w_tx_last;
    logic w_unused_tkeep;

    assign w_s_hs         = s_axis.tvalid & r_tready;
    assign w_tx_valid     = (r_state == c_ST_TX);
    assign w_tx_last      = w_tx_valid && (r_tx_idx == c_TX_LAST);
    assign w_m_hs         = w_tx_valid & m_axis.tready;
    assign w_unused_tkeep = ^s_axis.tkeep;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_RX: begin
                if (w_s_hs && (r_rx_idx == c_RX_LAST))
                    w_state_nxt = s_axis.tlast ? c_ST_STROBE : c_ST_DROP;
            end
            c_ST_DROP: begin
                if (w_s_hs && s_axis.tlast)
                    w_state_nxt = c_ST_RX;
            end
            c_ST_STROBE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT: begin
                if (dut2vip_valid)
                    w_state_nxt = c_ST_TX;
            end
            c_ST_TX: begin
                if (w_m_hs && w_tx_last)
                    w_state_nxt = c_ST_RX;
            end
            default: w_state_nxt = c_ST_RX;
        endcase
    end

    // tready is registered from the next state so it never depends on an input combinationally
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state         <= c_ST_RX;
            r_rx_idx        <= '0;
            r_tx_idx        <= '0;
            r_tready        <= 1'b0;
            r_req           <= '{default: '0};
            r_resp          <= '{default: '0};
            r_pkt_cnt       <= '0;
            r_err_short_cnt <= '0;
            r_err_long_cnt  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= (w_state_nxt == c_ST_RX) || (w_state_nxt == c_ST_DROP);
            case (r_state)
                c_ST_RX: begin
                    if (w_s_hs) begin
                        r_req[r_rx_idx] <= s_axis.tdata;
                        if (r_rx_idx == c_RX_LAST) begin
                            r_rx_idx <= '0;
                        end else if (s_axis.tlast) begin
                            r_rx_idx <= '0;
                            if (r_err_short_cnt != c_CNT_MAX)
                                r_err_short_cnt <= r_err_short_cnt + c_CNT_ONE;
                        end else begin
                            r_rx_idx <= r_rx_idx + c_RX_ONE;
                        end
                    end
                end
                c_ST_DROP: begin
                    if (w_s_hs && s_axis.tlast) begin
                        r_rx_idx <= '0;
                        if (r_err_long_cnt != c_CNT_MAX)
                            r_err_long_cnt <= r_err_long_cnt + c_CNT_ONE;
                    end
                end
                c_ST_WAIT: begin
                    if (dut2vip_valid) begin
                        r_tx_idx <= '0;
                        for (int k = 0; k < DUT2VIP_WORDS_NUM; k++)
                            r_resp[k] <= dut2vip_bus[k*C_DATA_WIDTH +: C_DATA_WIDTH];
                    end
                end
                c_ST_TX: begin
                    if (w_m_hs) begin
                        if (w_tx_last) begin
                            r_tx_idx <= '0;
                            r_rx_idx <= '0;
                            if (r_pkt_cnt != c_CNT_MAX)
                                r_pkt_cnt <= r_pkt_cnt + c_CNT_ONE;
                        end else begin
                            r_tx_idx <= r_tx_idx + c_TX_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < VIP2DUT_WORDS_NUM; i++) begin : g_req_pack
            assign vip2dut_bus[i*C_DATA_WIDTH +: C_DATA_WIDTH] = r_req[i];
        end
    endgenerate

    assign s_axis.tready = r_tready;
    assign m_axis.tvalid = w_tx_valid;
    assign m_axis.tdata  = w_tx_valid ? r_resp[r_tx_idx] : '0;
    assign m_axis.tkeep  = {(C_DATA_WIDTH/8){w_tx_valid}};
    assign m_axis.tlast  = w_tx_last;

    assign vip2dut_clk   = (r_state == c_ST_STROBE);
    assign pkt_cnt       = r_pkt_cnt;
    assign err_short_cnt = r_err_short_cnt;
    assign err_long_cnt  = r_err_long_cnt;
endmodule
`default_nettype wire

// File: tb/tb_vip_axis_pkt.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_axis_pkt
// Description : Scoreboard bench for vip_axis_pkt (10/10 words, 32-bit stream)
//               plus a 2-bit-counter instance for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_axis_pkt;
    localparam int W    = 32;
    localparam int NQ   = 10;
    localparam int NR   = 10;
    localparam int CW   = 16;
    localparam int BUSQ = W*NQ;
    localparam int BUSR = W*NR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic              dut_valid;
    logic [BUSR-1:0]   dut_bus;
    logic              vip2dut_clk;
    logic [BUSQ-1:0]   vip2dut_bus;
    logic [CW-1:0]     pkt_cnt, err_short_cnt, err_long_cnt;

    vip_axis_pkt_if #(.DATA_WIDTH(W)) s_if ();
    vip_axis_pkt_if #(.DATA_WIDTH(W)) m_if ();

    vip_axis_pkt #(.C_DATA_WIDTH(W), .VIP2DUT_WORDS_NUM(NQ), .DUT2VIP_WORDS_NUM(NR), .CNT_WIDTH(CW)) dut (
        .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis(s_if), .m_axis(m_if),
        .vip2dut_clk(vip2dut_clk), .vip2dut_bus(vip2dut_bus),
        .dut2vip_valid(dut_valid), .dut2vip_bus(dut_bus),
        .pkt_cnt(pkt_cnt), .err_short_cnt(err_short_cnt), .err_long_cnt(err_long_cnt)
    );

    // Second instance with narrow counters for the saturation scenario
    logic            sat_v2d_clk;
    logic [2*W-1:0]  sat_v2d_bus;
    logic [W-1:0]    sat_d2v_bus = '0;
    logic            sat_d2v_valid = 1'b0;
    logic [1:0]      sat_pkt, sat_short, sat_long;

    vip_axis_pkt_if #(.DATA_WIDTH(W)) sat_s ();
    vip_axis_pkt_if #(.DATA_WIDTH(W)) sat_m ();

    vip_axis_pkt #(.C_DATA_WIDTH(W), .VIP2DUT_WORDS_NUM(2), .DUT2VIP_WORDS_NUM(1), .CNT_WIDTH(2)) dut_sat (
        .s_axis_aclk(clk), .s_axis_areset(rst), .s_axis(sat_s), .m_axis(sat_m),
        .vip2dut_clk(sat_v2d_clk), .vip2dut_bus(sat_v2d_bus),
        .dut2vip_valid(sat_d2v_valid), .dut2vip_bus(sat_d2v_bus),
        .pkt_cnt(sat_pkt), .err_short_cnt(sat_short), .err_long_cnt(sat_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobe = 0;
    int strobe_cyc = -1;
    int last_hs = 0;
    int exp_pkt = 0, exp_short = 0, exp_long = 0;

    logic [BUSQ-1:0] req_q[$];
    logic [W:0]      resp_q[$];
    int              rcyc_q[$];

    // Monitor: strobes checked against pushed requests, response handshakes popped from the scoreboard
    initial begin
        logic          prev_stall;
        logic [W-1:0]  prev_data;
        logic          prev_last;
        logic [BUSQ-1:0] eb;
        logic [W:0]    er;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (vip2dut_clk === 1'b1) begin
                    n_strobe++;
                    strobe_cyc = cyc;
                    n_tests++;
                    if (req_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL strobe_unexpected: vip2dut_clk=1 at cycle %0d, required no strobe", cyc);
                    end else begin
                        eb = req_q.pop_front();
                        if (vip2dut_bus !== eb) begin
                            n_fail++;
                            $display("FAIL vip2dut_bus: got %h, required %h", vip2dut_bus, eb);
                        end
                    end
                end
                if (prev_stall) begin
                    n_tests++;
                    if (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data || m_if.tlast !== prev_last) begin
                        n_fail++;
                        $display("FAIL resp_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                                 m_if.tvalid, m_if.tdata, m_if.tlast, prev_data, prev_last);
                    end
                end
                if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
                    n_tests++;
                    rcyc_q.push_back(cyc);
                    if (resp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL resp_unexpected: got word %h, required no response", m_if.tdata);
                    end else begin
                        er = resp_q.pop_front();
                        if (m_if.tdata !== er[W-1:0] || m_if.tlast !== er[W] || m_if.tkeep !== 4'hF) begin
                            n_fail++;
                            $display("FAIL resp_word: got d=%h l=%b k=%h, required d=%h l=%b k=f",
                                     m_if.tdata, m_if.tlast, m_if.tkeep, er[W-1:0], er[W]);
                        end
                    end
                end
                prev_stall = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
                prev_data  = m_if.tdata;
                prev_last  = m_if.tlast;
            end
        end
    end

    task automatic push_good(input logic [W-1:0] req_base, input logic [W-1:0] resp_base);
        logic [BUSQ-1:0] v;
        for (int i = 0; i < NQ; i++) v[i*W +: W] = req_base + W'(i);
        req_q.push_back(v);
        for (int k = 0; k < NR; k++) begin
            dut_bus[k*W +: W] = resp_base + W'(k);
            resp_q.push_back({(k == NR-1), resp_base + W'(k)});
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last);
        int k;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_if.tready === 1'b1) break;
        end
        @(posedge clk); #1;
        last_hs = cyc;
        if (k == 50) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: tready low for 50 cycles, required 1");
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int n, input int last_at, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) send_word(base + W'(i), (i == last_at));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 300; k++) begin
            if (resp_q.size() == 0 && req_q.size() == 0 && s_if.tready === 1'b1) break;
            @(posedge clk); #1;
        end
        if (k == 300) begin
            n_tests++; n_fail++;
            $display("FAIL idle_timeout: %0d req / %0d resp pending, required 0", req_q.size(), resp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tkeep !== 4'h0 ||
            m_if.tdata !== '0 || vip2dut_clk !== 1'b0 || vip2dut_bus !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b v=%b l=%b k=%h d=%h clk=%b bus_nz=%b, required all 0",
                     s_if.tready, m_if.tvalid, m_if.tlast, m_if.tkeep, m_if.tdata, vip2dut_clk, |vip2dut_bus);
        end
        n_tests++;
        if (pkt_cnt !== 0 || err_short_cnt !== 0 || err_long_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d, required 0/0/0", pkt_cnt, err_short_cnt, err_long_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (s_if.tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_tready: got %b, required 1", s_if.tready);
        end
    endtask

    task automatic test_nominal();
        int s0;
        s0 = n_strobe;
        rcyc_q.delete();
        push_good(32'h0, 32'h100);
        send_pkt(NQ, NQ-1, 32'h0);
        exp_pkt++;
        wait_idle();
        n_tests++;
        if (n_strobe - s0 != 1 || strobe_cyc != last_hs) begin
            n_fail++;
            $display("FAIL nominal_strobe: got %0d strobes at cycle %0d, required 1 at cycle %0d",
                     n_strobe - s0, strobe_cyc, last_hs);
        end
        n_tests++;
        if (rcyc_q.size() != NR || rcyc_q[NR-1] - rcyc_q[0] != NR-1) begin
            n_fail++;
            $display("FAIL nominal_consecutive: got %0d words, required %0d on consecutive cycles", rcyc_q.size(), NR);
        end
        n_tests++;
        if (pkt_cnt !== CW'(exp_pkt)) begin
            n_fail++;
            $display("FAIL nominal_pkt_cnt: got %0d, required %0d", pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_short();
        int s0;
        s0 = n_strobe;
        send_pkt(4, 3, 32'h50);
        exp_short++;
        push_good(32'h20, 32'h300);
        send_pkt(NQ, NQ-1, 32'h20);
        exp_pkt++;
        wait_idle();
        n_tests++;
        if (err_short_cnt !== CW'(exp_short) || n_strobe - s0 != 1 || pkt_cnt !== CW'(exp_pkt)) begin
            n_fail++;
            $display("FAIL short_pkt: got short=%0d strobes=%0d pkt=%0d, required %0d/1/%0d",
                     err_short_cnt, n_strobe - s0, pkt_cnt, exp_short, exp_pkt);
        end
    endtask

    task automatic test_long();
        int s0;
        s0 = n_strobe;
        for (int i = 0; i < 13; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'h70 + W'(i);
            s_if.tlast  = (i == 12);
            @(negedge clk);
            n_tests++;
            if (s_if.tready !== 1'b1) begin
                n_fail++;
                $display("FAIL long_tready: word %0d got %b, required 1", i, s_if.tready);
            end
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        exp_long++;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (n_strobe != s0 || err_long_cnt !== CW'(exp_long)) begin
            n_fail++;
            $display("FAIL long_pkt: got strobes=%0d long=%0d, required 0/%0d", n_strobe - s0, err_long_cnt, exp_long);
        end
        push_good(32'h40, 32'h400);
        send_pkt(NQ, NQ-1, 32'h40);
        exp_pkt++;
        wait_idle();
        n_tests++;
        if (pkt_cnt !== CW'(exp_pkt) || err_long_cnt !== CW'(exp_long)) begin
            n_fail++;
            $display("FAIL long_followup: got pkt=%0d long=%0d, required %0d/%0d", pkt_cnt, err_long_cnt, exp_pkt, exp_long);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int i;
        logic [3:0] pat;
        pat = 4'b1001;
        s0 = n_strobe;
        dut_valid = 1'b0;
        push_good(32'h60, 32'h200);
        send_pkt(NQ, NQ-1, 32'h60);
        exp_pkt++;
        for (i = 0; i < 20 && n_strobe == s0; i++) begin
            @(posedge clk); #1;
        end
        repeat (6) begin
            @(posedge clk); #1;
        end
        dut_valid = 1'b1;
        n_tests++;
        if (m_if.tvalid !== 1'b0 || n_strobe - s0 != 1) begin
            n_fail++;
            $display("FAIL bp_wait: got tvalid=%b strobes=%0d, required 0/1", m_if.tvalid, n_strobe - s0);
        end
        @(posedge clk); #1;
        n_tests++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'h200) begin
            n_fail++;
            $display("FAIL bp_tvalid_latency: got v=%b d=%h, required v=1 d=00000200", m_if.tvalid, m_if.tdata);
        end
        for (i = 0; i < 100 && resp_q.size() != 0; i++) begin
            m_if.tready = pat[i % 4];
            @(negedge clk);
            n_tests++;
            if (s_if.tready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_s_tready: got %b during response, required 0", s_if.tready);
            end
            @(posedge clk); #1;
        end
        m_if.tready = 1'b1;
        n_tests++;
        if (resp_q.size() != 0 || s_if.tready !== 1'b1 || pkt_cnt !== CW'(exp_pkt)) begin
            n_fail++;
            $display("FAIL bp_done: got pending=%0d tready=%b pkt=%0d, required 0/1/%0d",
                     resp_q.size(), s_if.tready, pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_reset_mid();
        int i;
        push_good(32'h80, 32'h500);
        send_pkt(NQ, NQ-1, 32'h80);
        for (i = 0; i < 50 && resp_q.size() > NR-3; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_q.delete();
        req_q.delete();
        exp_pkt = 0; exp_short = 0; exp_long = 0;
        n_tests++;
        if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tkeep !== 4'h0 ||
            m_if.tdata !== '0 || vip2dut_clk !== 1'b0 || vip2dut_bus !== '0 ||
            pkt_cnt !== 0 || err_short_cnt !== 0 || err_long_cnt !== 0) begin
            n_fail++;
            $display("FAIL midreset_state: got rdy=%b v=%b d=%h bus_nz=%b cnt=%0d/%0d/%0d, required all 0",
                     s_if.tready, m_if.tvalid, m_if.tdata, |vip2dut_bus, pkt_cnt, err_short_cnt, err_long_cnt);
        end
        @(posedge clk); #1;
        push_good(32'h90, 32'h600);
        send_pkt(NQ, NQ-1, 32'h90);
        exp_pkt++;
        wait_idle();
        n_tests++;
        if (pkt_cnt !== CW'(exp_pkt)) begin
            n_fail++;
            $display("FAIL midreset_followup_pkt_cnt: got %0d, required %0d", pkt_cnt, exp_pkt);
        end
    endtask

    task automatic test_saturation();
        int k;
        int exp;
        for (int p = 1; p <= 5; p++) begin
            sat_s.tvalid = 1'b1;
            sat_s.tdata  = W'(p);
            sat_s.tlast  = 1'b1;
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (sat_s.tready === 1'b1) break;
            end
            @(posedge clk); #1;
            sat_s.tvalid = 1'b0;
            sat_s.tlast  = 1'b0;
            exp = (p > 3) ? 3 : p;
            n_tests++;
            if (sat_short !== 2'(exp) || k == 50) begin
                n_fail++;
                $display("FAIL sat_short_cnt: after %0d short packets got %0d, required %0d", p, sat_short, exp);
            end
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '1; s_if.tlast = 1'b0;
        m_if.tready = 1'b1;
        sat_s.tvalid = 1'b0; sat_s.tdata = '0; sat_s.tkeep = '1; sat_s.tlast = 1'b0;
        sat_m.tready = 1'b1;
        dut_valid = 1'b1;
        dut_bus   = '0;
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vip_axis_pkt.md
# vip_axis_pkt

Parametrised AXI-Stream virtual-IP bridge: collects a fixed-length packet from the slave stream into a wide parallel bus, strobes it into the DUT, waits for the DUT to flag its result, and returns the DUT result bus as a fixed-length packet on the master stream. It succeeds the fixed-length VIP bridge with:
- independent request/response lengths;
- an explicit DUT result handshake;
- packet-length checking with discard of malformed packets;
- saturating error/packet counters.

It sits between the host DMA streams and a DUT under test.

## Interface
Parameters:
- C_DATA_WIDTH, 128, stream word width in bits (multiple of 8)
- VIP2DUT_WORDS_NUM, 10, words per request packet (>=1)
- DUT2VIP_WORDS_NUM, 10, words per response packet (>=1)
- CNT_WIDTH, 16, width of status counters

Ports:
- s_axis_aclk  in  1  the single clock; all logic on rising edge
- s_axis_areset  in  1  synchronous, active-high reset
- s_axis_tvalid  in  1  request stream valid
- s_axis_tready  out  1  request stream ready
- s_axis_tdata  in  C_DATA_WIDTH  request word
- s_axis_tkeep  in  C_DATA_WIDTH/8  ignored
- s_axis_tlast  in  1  request end of packet
- m_axis_tvalid  out  1  response valid
- m_axis_tready  in  1  response ready
- m_axis_tdata  out  C_DATA_WIDTH  response word
- m_axis_tkeep  out  C_DATA_WIDTH/8  all ones while m_axis_tvalid, else 0
- m_axis_tlast  out  1  high on the final response word
- vip2dut_clk  out  1  one-cycle strobe: vip2dut_bus holds a complete request
- vip2dut_bus  out  C_DATA_WIDTH*VIP2DUT_WORDS_NUM  request; word i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]
- dut2vip_valid  in  1  DUT result ready (level, sampled in WAIT only)
- dut2vip_bus  in  C_DATA_WIDTH*DUT2VIP_WORDS_NUM  DUT result, same word packing
- pkt_cnt  out  CNT_WIDTH  completed transactions (response tlast handshakes), saturating
- err_short_cnt  out  CNT_WIDTH  request packets with tlast before word VIP2DUT_WORDS_NUM-1, saturating
- err_long_cnt  out  CNT_WIDTH  request packets without tlast on word VIP2DUT_WORDS_NUM-1, saturating

## Operation
Handshakes:
- A request handshake is s_axis_tvalid & s_axis_tready.
- A response handshake is m_axis_tvalid & m_axis_tready.

States:
- RX: s_axis_tready=1. Each handshake writes s_axis_tdata into vip2dut_bus word rx_idx, then increments rx_idx.
  - Handshake with rx_idx==VIP2DUT_WORDS_NUM-1 and tlast=1: go to STROBE.
  - Same word with tlast=0: go to DROP.
  - Handshake with tlast=1 and rx_idx<VIP2DUT_WORDS_NUM-1: err_short_cnt++, rx_idx<=0, stay in RX, no strobe. Words already written stay in vip2dut_bus and are overwritten by the next packet.
- DROP: s_axis_tready=1, data discarded. On a tlast handshake: err_long_cnt++, rx_idx<=0, go to RX.
- STROBE: vip2dut_clk=1 for exactly this cycle; s_axis_tready=0; go to WAIT.
- WAIT: s_axis_tready=0. When dut2vip_valid=1: latch dut2vip_bus into the internal response register, tx_idx<=0, go to TX.
- TX: m_axis_tvalid=1, m_axis_tdata = latched word tx_idx, m_axis_tlast=(tx_idx==DUT2VIP_WORDS_NUM-1).
  - Each handshake increments tx_idx.
  - Handshake on the last word: pkt_cnt++, rx_idx<=0, go to RX.
  - m_axis_tdata, m_axis_tlast and m_axis_tkeep stay stable while m_axis_tready=0.

General rules:
- vip2dut_bus is not written outside RX, so it is stable from STROBE until the next request packet starts.
- Counters saturate at all ones and do not wrap.
- With VIP2DUT_WORDS_NUM=1: a single word with tlast goes straight to STROBE; a single word without tlast goes to DROP.

## Timing
- Reset (synchronous, s_axis_areset=1 at a clock edge) → state RX, rx_idx=tx_idx=0.
- Reset values of outputs and registers:
  - s_axis_tready=0 while reset is asserted, 1 on the first cycle after it deasserts
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0
  - vip2dut_clk=0, vip2dut_bus=0
  - all counters 0
  - response register 0
- Reset asserted in any state aborts the transaction immediately with no strobe and no counter update.
- Latency:
  - Last request handshake at cycle t → vip2dut_clk=1 at t+1, last word visible on vip2dut_bus at t+1.
  - dut2vip_valid is first sampled at t+2. If it is already high then, m_axis_tvalid=1 at t+3.
  - dut2vip_valid high at cycle u (in WAIT) → m_axis_tvalid=1 at u+1 with word 0.
- Throughput: with m_axis_tready=1, one response word per cycle. After the final response handshake at v, s_axis_tready=1 at v+1.
- All outputs are registered or decoded from registered state. There is no combinational path from an input to an output.

## Test plan
- **Nominal:** WORDS 10/10; send words 0..9 with data=index and tlast on word 9; dut2vip_bus word k = 0x100+k; dut2vip_valid held at 1; m_axis_tready=1. Expect:
  - vip2dut_clk high exactly once, one cycle after the word-9 handshake
  - vip2dut_bus word i = i
  - response words 0x100..0x109 on consecutive cycles, tlast only on word 9, tkeep all ones
  - pkt_cnt=1
- **Short packet:** send 4 words with tlast on word 3, then one nominal packet. Expect err_short_cnt=1, a single vip2dut_clk pulse (for the second packet), pkt_cnt=1.
- **Long packet:** send 13 words with tlast on word 12, then one nominal packet. Expect err_long_cnt=1, no strobe for the long packet, s_axis_tready=1 throughout the long packet, the nominal packet processed normally.
- **Backpressure and DUT delay:** dut2vip_valid rises 7 cycles after the strobe; m_axis_tready toggles 1,0,0,1 repeatedly. Expect:
  - m_axis_tvalid rises exactly 1 cycle after dut2vip_valid rises
  - m_axis_tdata and m_axis_tlast stable while m_axis_tready=0
  - all 10 response words delivered in order
  - s_axis_tready=0 until the last response handshake
- **Reset mid-operation:** assert s_axis_areset for 1 cycle during TX after 3 response words. Expect all outputs at reset values in the next cycle, counters 0, and a following nominal packet completing with pkt_cnt=1.
- **Saturation:** with CNT_WIDTH=2, send 5 short packets. Expect err_short_cnt to stop at 3.
